mult_div_unit: RTL and testbench

Iterative multiply/divide unit with HI/LO result registers for the MIPS datapath, parametrised in operand width. It extends the single-cycle ALU with signed and unsigned 2·WIDTH-bit multiply and divide/remainder, executed over multiple cycles behind a start/busy/done handshake. It sits beside the ALU in the execute stage; the controller stalls while `busy` is high and reads `hi`/`lo` for MFHI/MFLO.

---
 rtl/mult_div_unit.sv | 107 ++++++++++
 tb/tb_mult_div_unit.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative signed/unsigned multiply and divide with HI/LO registers.
// One bit per cycle for WIDTH cycles, then a sign-fix cycle that writes hi/lo.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             hi_we_i,
  input  logic             lo_we_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, prod;
  logic [WIDTH-1:0] m_q, m_d, hi_q, hi_d, lo_q, lo_d;
  logic div_q, div_d, neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d, done_q, done_d;
  logic sa, sb, ge;
  logic [WIDTH-1:0] abs_a, abs_b, diff, quo, rem;
  logic [WIDTH:0] msum, shifted;
  assign sa = op_i[0] & a_i[WIDTH-1];
  assign sb = op_i[0] & b_i[WIDTH-1];
  assign abs_a = sa ? -a_i : a_i;
  assign abs_b = sb ? -b_i : b_i;
  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  assign msum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
  assign shifted = acc_q[2*WIDTH-1:WIDTH-1];
  assign ge = shifted >= {1'b0, m_q};
  assign diff = shifted[WIDTH-1:0] - m_q;
  assign prod = neg_q ? -acc_q : acc_q;
  assign quo = dz_q ? '1 : neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      acc_q <= '0;
      m_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      div_q <= 1'b0;
      neg_q <= 1'b0;
      rneg_q <= 1'b0;
      dz_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      m_q <= m_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      div_q <= div_d;
      neg_q <= neg_d;
      rneg_q <= rneg_d;
      dz_q <= dz_d;
      done_q <= done_d;
    end
  end
  always_comb
    state_d = state_q == IDLE ? (start_i ? RUN : IDLE) :
              state_q == RUN  ? (cnt_q == CW'(1) ? FIX : RUN) : IDLE;
  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    m_d = m_q;
    hi_d = hi_q;
    lo_d = lo_q;
    div_d = div_q;
    neg_d = neg_q;
    rneg_d = rneg_q;
    dz_d = dz_q;
    done_d = state_q == FIX;
    if (state_q == IDLE) begin
      if (hi_we_i) hi_d = wdata_i;
      if (lo_we_i) lo_d = wdata_i;
      if (start_i) begin
        cnt_d = CW'(WIDTH);
        div_d = op_i[1];
        neg_d = sa ^ sb;
        rneg_d = sa;
        dz_d = op_i[1] & ~|b_i;
        acc_d = {{WIDTH{1'b0}}, op_i[1] ? abs_a : abs_b};
        m_d = op_i[1] ? abs_b : abs_a;
      end
    end else if (state_q == RUN) begin
      cnt_d = cnt_q - CW'(1);
      acc_d = div_q ? {ge ? diff : shifted[WIDTH-1:0], acc_q[WIDTH-2:0], ge} : {msum, acc_q[WIDTH-1:1]};
    end else if (state_q == FIX) begin
      hi_d = div_q ? rem : prod[2*WIDTH-1:WIDTH];
      lo_d = div_q ? quo : prod[WIDTH-1:0];
    end
  end
  always_comb busy_o = state_q != IDLE;
  assign done_o = done_q;
  assign hi_o = hi_q;
  assign lo_o = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed and random checks of 32-bit and 8-bit units against an arithmetic model.
module tb_mult_div_unit;
  logic clk = 1'b0, reset = 1'b1, s32 = 1'b0, s8 = 1'b0, hwe = 1'b0, lwe = 1'b0;
  logic [1:0] op_r = '0;
  logic [31:0] a_r = '0, b_r = '0, wd = '0, hi32, lo32;
  logic [7:0] hi8, lo8;
  logic busy32, done32, busy8, done8;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  mult_div_unit #(.WIDTH(32)) u32 (
    .clk(clk), .reset(reset), .start_i(s32), .op_i(op_r), .a_i(a_r), .b_i(b_r),
    .hi_we_i(hwe), .lo_we_i(lwe), .wdata_i(wd),
    .busy_o(busy32), .done_o(done32), .hi_o(hi32), .lo_o(lo32));
  mult_div_unit #(.WIDTH(8)) u8 (
    .clk(clk), .reset(reset), .start_i(s8), .op_i(op_r), .a_i(a_r[7:0]), .b_i(b_r[7:0]),
    .hi_we_i(1'b0), .lo_we_i(1'b0), .wdata_i(wd[7:0]),
    .busy_o(busy8), .done_o(done8), .hi_o(hi8), .lo_o(lo8));
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // {hi, lo} from plain integer arithmetic on the operands reduced to w bits
  function automatic logic [63:0] ref_model(input int w, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint m, x, y, p;
    m = (longint'(1) << w) - 1;
    x = longint'(a) & m;
    y = longint'(b) & m;
    if (op[0]) begin
      if (x[w-1]) x -= longint'(1) << w;
      if (y[w-1]) y -= longint'(1) << w;
    end
    if (!op[1]) begin
      p = x * y;
      return {32'((p >>> w) & m), 32'(p & m)};
    end
    if (y == 0) return {32'(x & m), 32'(m)};
    return {32'((x % y) & m), 32'((x / y) & m)};
  endfunction
  function automatic logic [63:0] res(input int w);
    return w == 32 ? {hi32, lo32} : {24'b0, hi8, 24'b0, lo8};
  endfunction
  task automatic wait_done(input int w, output int n, output int bc);
    logic dn;
    n = 0;
    bc = 0;
    dn = w == 32 ? done32 : done8;
    while (!dn && n < 200) begin
      bc += int'(w == 32 ? busy32 : busy8);
      @(negedge clk);
      n++;
      dn = w == 32 ? done32 : done8;
    end
  endtask
  task automatic do_op(input int w, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
    int n, bc;
    logic [63:0] exp;
    exp = ref_model(w, op, a, b);
    @(negedge clk);
    op_r = op; a_r = a; b_r = b;
    if (w == 32) s32 = 1'b1; else s8 = 1'b1;
    @(negedge clk);
    s32 = 1'b0; s8 = 1'b0;
    op_r = 2'($urandom); a_r = $urandom; b_r = $urandom;
    wait_done(w, n, bc);
    check({tag, ":lat"}, 64'(n), 64'(w + 1));
    check({tag, ":busy_cycles"}, 64'(bc), 64'(w + 1));
    check({tag, ":busy_at_done"}, 64'(w == 32 ? busy32 : busy8), 64'(0));
    check({tag, ":result"}, res(w), exp);
    @(negedge clk);
    check({tag, ":done_pulse"}, 64'(w == 32 ? done32 : done8), 64'(0));
  endtask
  function automatic logic [31:0] pick(input int w);
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0: v = 0;
      1: v = 32'hFFFFFFFF;
      2: v = 32'(1) << (w - 1);
      3: v = $urandom_range(0, 9);
      default: v = $urandom;
    endcase
    return v;
  endfunction
  initial begin
    int n, bc, dcnt;
    logic [63:0] exp;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst:busy32", 64'(busy32), 64'(0));
    check("rst:done32", 64'(done32), 64'(0));
    check("rst:hilo32", {hi32, lo32}, 64'(0));
    check("rst:hilo8", {48'b0, hi8, lo8}, 64'(0));
    do_op(32, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu_max");
    do_op(32, 2'b01, 32'hFFFFFFFD, 32'd5, "mult_neg");
    do_op(32, 2'b11, 32'hFFFFFFF9, 32'd2, "div_neg");
    do_op(32, 2'b11, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
    do_op(32, 2'b10, 32'h00001234, 32'd0, "divu_zero");
    do_op(32, 2'b11, 32'hFFFFFF00, 32'd0, "div_zero_neg");
    do_op(32, 2'b10, 32'd100, 32'd7, "divu_100_7");
    do_op(8, 2'b11, 32'h80, 32'hFF, "div8_ovf");
    do_op(8, 2'b01, 32'h80, 32'h80, "mult8_min");
    @(negedge clk);
    hwe = 1'b1; wd = 32'hA5A5A5A5;
    @(negedge clk);
    hwe = 1'b0;
    check("mthi", 64'(hi32), 64'hA5A5A5A5);
    lwe = 1'b1; wd = 32'h0BADF00D;
    @(negedge clk);
    lwe = 1'b0;
    check("mtlo", 64'(lo32), 64'h0BADF00D);
    exp = ref_model(32, 2'b00, 32'h00012345, 32'h00006789);
    op_r = 2'b00; a_r = 32'h00012345; b_r = 32'h00006789; s32 = 1'b1; hwe = 1'b1; wd = 32'h5A5A5A5A;
    @(negedge clk);
    s32 = 1'b0; hwe = 1'b0;
    check("mthi_with_start", 64'(hi32), 64'h5A5A5A5A);
    repeat (5) @(negedge clk);
    s32 = 1'b1; op_r = 2'b11; a_r = 32'd7; b_r = 32'd0; lwe = 1'b1; wd = 32'hFFFF0000;
    @(negedge clk);
    s32 = 1'b0; lwe = 1'b0;
    check("mtlo_in_run", 64'(lo32), 64'h0BADF00D);
    check("hi_hold_run", 64'(hi32), 64'h5A5A5A5A);
    wait_done(32, n, bc);
    check("restart:lat", 64'(n + 6), 64'(33));
    check("restart:result", {hi32, lo32}, exp);
    exp = ref_model(32, 2'b10, 32'd100, 32'd7);
    op_r = 2'b10; a_r = 32'd100; b_r = 32'd7; s32 = 1'b1;
    @(negedge clk);
    s32 = 1'b0;
    wait_done(32, n, bc);
    check("b2b:lat", 64'(n), 64'(33));
    check("b2b:result", {hi32, lo32}, exp);
    @(negedge clk);
    op_r = 2'b00; a_r = 32'hDEADBEEF; b_r = 32'h12345678; s32 = 1'b1;
    @(negedge clk);
    s32 = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort:busy", 64'(busy32), 64'(0));
    check("abort:done", 64'(done32), 64'(0));
    check("abort:hilo", {hi32, lo32}, 64'(0));
    dcnt = 0;
    repeat (40) begin
      @(negedge clk);
      dcnt += int'(done32);
    end
    check("abort:no_done", 64'(dcnt), 64'(0));
    for (int i = 0; i < 30; i++) do_op(32, 2'($urandom), pick(32), pick(32), $sformatf("rand32_%0d", i));
    for (int i = 0; i < 60; i++) do_op(8, 2'($urandom), pick(8), pick(8), $sformatf("rand8_%0d", i));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
